// File: rtl/rs232_pkg.sv
// -----------------------------------------------------------------------------
// rs232_pkg
// Shared definitions for the RS-232 receiver and transmitter.
//   - state_t           : receiver FSM states
//   - DEF_COUNT_BITS    : default width of the bit-period down-counter
//   - DEF_COUNT1        : default Clk cycles per bit
//   - DEF_COUNT0_5      : default Clk cycles from start edge to start-bit centre
// -----------------------------------------------------------------------------
package rs232_pkg;

  localparam int         DEF_COUNT_BITS = 5;
  localparam logic [4:0] DEF_COUNT1     = 5'd13;
  localparam logic [4:0] DEF_COUNT0_5   = 5'd6;

  typedef enum logic [2:0] {
    WAIT_IDLE = 3'd0,
    IDLE      = 3'd1,
    START     = 3'd2,
    DATA      = 3'd3,
    PARITY    = 3'd4,
    STOP      = 3'd5
  } state_t;

endpackage

// File: rtl/rs232_sync.sv
// -----------------------------------------------------------------------------
// rs232_sync
// Two-flop synchronizer for a single asynchronous input.
// Ports:
//   i_clk : destination clock
//   i_rst : asynchronous active-high reset; both flops load ResetVal
//   i_d   : asynchronous input
//   o_q   : synchronized output (two Clk cycles of latency)
// -----------------------------------------------------------------------------
module rs232_sync #(
  parameter logic ResetVal = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_meta <= ResetVal;
      r_sync <= ResetVal;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/rs232_rx.sv
// -----------------------------------------------------------------------------
// rs232_rx
// RS-232 / UART receiver, 8N1 (8E1 when RS232_RX_PARITY_EN is defined),
// LSB first, idle-high line. The line is sampled at the centre of each bit.
//
// Configuration macro: RS232_RX_PARITY_EN (adds an even-parity bit after D7).
//
// Ports:
//   Clk         : system clock, rising edge
//   Reset       : asynchronous active-high reset
//   Rx          : serial line, asynchronous to Clk, idle high
//   RxData      : last received byte, held until the next Valid
//   Valid       : one-cycle strobe, RxData/FrameError/ParityError valid with it
//   FrameError  : stop bit sampled low (qualified by Valid)
//   ParityError : parity mismatch (qualified by Valid; 0 without parity)
//   Busy        : high from start detection until the frame ends
//   DbgState    : current FSM state, for observation only
//
// Handshake: Valid is a pure strobe with no ready/back-pressure. The consumer
// must take RxData in the Valid cycle; the next byte overwrites it.
// -----------------------------------------------------------------------------
module rs232_rx
  import rs232_pkg::*;
#(
  parameter int                   CountBits = DEF_COUNT_BITS,
  parameter logic [CountBits-1:0] Count1    = CountBits'(DEF_COUNT1),
  parameter logic [CountBits-1:0] Count0_5  = CountBits'(DEF_COUNT0_5)
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Rx,
  output logic [7:0] RxData,
  output logic       Valid,
  output logic       FrameError,
  output logic       ParityError,
  output logic       Busy,
  output state_t     DbgState
);

  localparam logic [CountBits-1:0] BitReload  = Count1 - CountBits'(1);
  localparam logic [CountBits-1:0] HalfReload = Count0_5 - CountBits'(1);

  logic                 w_rxs;
  logic                 w_event;
  state_t               r_state;
  logic [CountBits-1:0] r_cnt;
  logic [2:0]           r_idx;
  logic [7:0]           r_shift;
  logic [1:0]           r_settle;
  logic [7:0]           r_data;
  logic                 r_valid;
  logic                 r_fe;
  logic                 r_pe;
  logic                 r_busy;
`ifdef RS232_RX_PARITY_EN
  logic                 r_par;
`endif

  rs232_sync #(.ResetVal(1'b1)) u_sync (
    .i_clk (Clk),
    .i_rst (Reset),
    .i_d   (Rx),
    .o_q   (w_rxs)
  );

  assign w_event = (r_cnt == '0);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state  <= WAIT_IDLE;
      r_cnt    <= '0;
      r_idx    <= 3'd0;
      r_shift  <= 8'h00;
      r_settle <= 2'b00;
      r_data   <= 8'h00;
      r_valid  <= 1'b0;
      r_fe     <= 1'b0;
      r_pe     <= 1'b0;
      r_busy   <= 1'b1;
`ifdef RS232_RX_PARITY_EN
      r_par    <= 1'b0;
`endif
    end else begin
      r_valid  <= 1'b0;
      // The synchronizer flops come out of reset holding 1, which is not a
      // real observation of the line. WAIT_IDLE ignores rxs until both
      // flops have been refilled from the pin.
      r_settle <= {r_settle[0], 1'b1};

      // Bit timer runs in every in-frame state; it reloads on its own event.
      if (r_state inside {START, DATA, PARITY, STOP}) begin
        r_cnt <= w_event ? BitReload : r_cnt - CountBits'(1);
      end

      case (r_state)
        WAIT_IDLE: begin
          if (r_settle[1] && w_rxs) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        IDLE: begin
          if (!w_rxs) begin
            r_cnt   <= HalfReload;
            r_busy  <= 1'b1;
            r_state <= START;
          end
        end
        START: begin
          if (w_event) begin
            if (!w_rxs) begin
              r_idx   <= 3'd0;
              r_state <= DATA;
            end else begin
              // Line went back high by the start-bit centre: a glitch.
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end
          end
        end
        DATA: begin
          if (w_event) begin
            r_shift <= {w_rxs, r_shift[7:1]};
            r_idx   <= r_idx + 3'd1;
            if (r_idx == 3'd7) begin
`ifdef RS232_RX_PARITY_EN
              r_state <= PARITY;
`else
              r_state <= STOP;
`endif
            end
          end
        end
`ifdef RS232_RX_PARITY_EN
        PARITY: begin
          if (w_event) begin
            r_par   <= w_rxs;
            r_state <= STOP;
          end
        end
`endif
        STOP: begin
          if (w_event) begin
            r_data  <= r_shift;
            r_valid <= 1'b1;
            r_fe    <= ~w_rxs;
`ifdef RS232_RX_PARITY_EN
            r_pe    <= (^r_shift) ^ r_par;
`else
            r_pe    <= 1'b0;
`endif
            if (w_rxs) begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end else begin
              // Break / held-low line: wait for idle so the low level is not
              // taken as the next start bit.
              r_state <= WAIT_IDLE;
            end
          end
        end
        default: begin
          r_state <= WAIT_IDLE;
          r_busy  <= 1'b1;
        end
      endcase
    end
  end

  assign RxData      = r_data;
  assign Valid       = r_valid;
  assign FrameError  = r_fe;
  assign ParityError = r_pe;
  assign Busy        = r_busy;
  assign DbgState    = r_state;

endmodule

// File: tb/tb_rs232_rx.sv
// -----------------------------------------------------------------------------
// tb_rs232_rx
// Self-checking bench for rs232_rx with the default 13-cycle bit period.
// Build with +define+RS232_RX_PARITY_EN to exercise the 8E1 variant.
// -----------------------------------------------------------------------------
module tb_rs232_rx;
  import rs232_pkg::*;

  localparam int C1 = 13;
`ifdef RS232_RX_PARITY_EN
  localparam int LAT = 2 + 6 + 9 * C1 + C1;
`else
  localparam int LAT = 2 + 6 + 9 * C1;
`endif

  // ---------------- clock / reset ----------------
  logic       Clk   = 1'b0;
  logic       Reset = 1'b1;
  logic       Rx    = 1'b0;
  logic [7:0] RxData;
  logic       Valid;
  logic       FrameError;
  logic       ParityError;
  logic       Busy;
  state_t     DbgState;

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  rs232_rx dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .Rx          (Rx),
    .RxData      (RxData),
    .Valid       (Valid),
    .FrameError  (FrameError),
    .ParityError (ParityError),
    .Busy        (Busy),
    .DbgState    (DbgState)
  );

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [9:0] word;   // {ParityError, FrameError, RxData}
    int         cyc;
  } obs_t;

  obs_t       obs_q[$];
  logic [9:0] exp_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;

  always @(negedge Clk) begin
    if (!Reset && Valid) obs_q.push_back('{word: {ParityError, FrameError, RxData}, cyc: cyc});
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Exactly one Valid since the last call, matching the head of exp_q, with
  // the first clock edge that samples the low start bit counted as cycle 0.
  task automatic compare_obs(input string nm, input int start_cyc);
    obs_t       o;
    logic [9:0] e;
    e = exp_q.pop_front();
    check({nm, "_valid_count"}, obs_q.size(), 1);
    if (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      check({nm, "_word"}, o.word, e);
      check({nm, "_latency"}, o.cyc - start_cyc - 1, LAT);
    end
    obs_q.delete();
  endtask

  // ---------------- drivers (called on a negedge) ----------------
  task automatic drive_bit(input logic b);
    Rx = b;
    repeat (C1) @(negedge Clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop,
`ifdef RS232_RX_PARITY_EN
                            input logic par,
`endif
                            output int st);
    st = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef RS232_RX_PARITY_EN
    drive_bit(par);
`endif
    drive_bit(stop);
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         gap;
    logic       exp_fe;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int st;

    vecs[0] = '{data: 8'hA5, stop: 1'b1, gap: 20, exp_fe: 1'b0};
    vecs[1] = '{data: 8'h00, stop: 1'b1, gap: 0,  exp_fe: 1'b0};
    vecs[2] = '{data: 8'hFF, stop: 1'b1, gap: 0,  exp_fe: 1'b0};
    vecs[3] = '{data: 8'h55, stop: 1'b1, gap: 15, exp_fe: 1'b0};
    vecs[4] = '{data: 8'h81, stop: 1'b1, gap: 10, exp_fe: 1'b0};
    vecs[5] = '{data: 8'hC3, stop: 1'b0, gap: 20, exp_fe: 1'b1};
    vecs[6] = '{data: 8'h6E, stop: 1'b1, gap: 20, exp_fe: 1'b0};

    // Reset values, with the line low throughout
    repeat (3) @(negedge Clk);
    check("rst_rxdata", RxData, 8'h00);
    check("rst_valid", Valid, 1'b0);
    check("rst_fe", FrameError, 1'b0);
    check("rst_pe", ParityError, 1'b0);
    check("rst_busy", Busy, 1'b1);
    check("rst_state", 32'(DbgState), 32'(WAIT_IDLE));

    // Release with Rx held low: stays busy, never reports a byte
    Reset = 1'b0;
    repeat (50) @(negedge Clk);
    check("lowrel_busy", Busy, 1'b1);
    check("lowrel_no_valid", obs_q.size(), 0);
    Rx = 1'b1;
    repeat (6) @(negedge Clk);
    check("lowrel_busy_clear", Busy, 1'b0);
    check("lowrel_state", 32'(DbgState), 32'(IDLE));
    repeat (10) @(negedge Clk);

    // Table-driven frames (includes back-to-back 00/FF/55 and a framing error)
    for (int i = 0; i < 7; i++) begin
      exp_q.push_back({1'b0, vecs[i].exp_fe, vecs[i].data});
`ifdef RS232_RX_PARITY_EN
      send_frame(vecs[i].data, vecs[i].stop, ^vecs[i].data, st);
`else
      send_frame(vecs[i].data, vecs[i].stop, st);
`endif
      compare_obs($sformatf("vec%0d", i), st);
      Rx = 1'b1;
      repeat (vecs[i].gap) @(negedge Clk);
      check($sformatf("vec%0d_hold", i), RxData, vecs[i].data);
    end

    // False start: 3-cycle low glitch
    Rx = 1'b0;
    repeat (3) @(negedge Clk);
    Rx = 1'b1;
    repeat (2) @(negedge Clk);
    check("glitch_busy_set", Busy, 1'b1);
    repeat (10) @(negedge Clk);
    check("glitch_busy_clear", Busy, 1'b0);
    check("glitch_state", 32'(DbgState), 32'(IDLE));
    check("glitch_no_valid", obs_q.size(), 0);
    repeat (10) @(negedge Clk);

    // Framing error followed by a line held low for 40 cycles
    exp_q.push_back({1'b0, 1'b1, 8'h3C});
`ifdef RS232_RX_PARITY_EN
    send_frame(8'h3C, 1'b0, 1'b0, st);
`else
    send_frame(8'h3C, 1'b0, st);
`endif
    repeat (40) @(negedge Clk);
    compare_obs("break", st);
    check("break_busy", Busy, 1'b1);
    check("break_state", 32'(DbgState), 32'(WAIT_IDLE));
    Rx = 1'b1;
    repeat (20) @(negedge Clk);
    check("break_no_valid", obs_q.size(), 0);
    check("break_busy_clear", Busy, 1'b0);

`ifdef RS232_RX_PARITY_EN
    // 8'h07 has three ones: even parity bit is 1
    exp_q.push_back({1'b0, 1'b0, 8'h07});
    send_frame(8'h07, 1'b1, 1'b1, st);
    compare_obs("par_ok", st);
    Rx = 1'b1;
    repeat (10) @(negedge Clk);
    exp_q.push_back({1'b1, 1'b0, 8'h07});
    send_frame(8'h07, 1'b1, 1'b0, st);
    compare_obs("par_bad", st);
    Rx = 1'b1;
    repeat (10) @(negedge Clk);
`endif

    // Reset during data bit 4: partial byte discarded, outputs at reset values
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(i[0]);
    Rx = 1'b1;
    repeat (6) @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    check("midrst_rxdata", RxData, 8'h00);
    check("midrst_valid", Valid, 1'b0);
    check("midrst_fe", FrameError, 1'b0);
    check("midrst_pe", ParityError, 1'b0);
    check("midrst_busy", Busy, 1'b1);
    check("midrst_state", 32'(DbgState), 32'(WAIT_IDLE));
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    repeat (200) @(negedge Clk);
    check("midrst_no_valid", obs_q.size(), 0);
    check("midrst_busy_clear", Busy, 1'b0);
    check("midrst_rxdata_after", RxData, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
